// File: rtl/rs_tomasulo_param.sv
// rs_tomasulo_param: parametrised Tomasulo reservation station.
// It includes a built-in register rename table, CDB wakeup and a registered
// dispatch stage that feeds the ALU and memory units.
// Optional build macro RS_AGE_ORDER_EN: dispatch the oldest READY entry
// instead of the lowest-index READY entry.
module rs_tomasulo_param #(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 16,
    parameter int  REG_W  = 4,
    parameter int  OP_W   = 4,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_W-1:0]  issue_dst,
    input  logic [REG_W-1:0]  issue_src_b,
    input  logic [REG_W-1:0]  issue_src_c,
    input  logic [DATA_W-1:0] issue_val_b,
    input  logic [DATA_W-1:0] issue_val_c,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [TAG_W-1:0]  disp_tag,
    output logic [OP_W-1:0]   disp_op,
    output logic [REG_W-1:0]  disp_dst,
    output logic [DATA_W-1:0] disp_b,
    output logic [DATA_W-1:0] disp_c,
    output logic [TAG_W:0]    count
);
    localparam int NREG = 2**REG_W;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_RUN} entryState_t;

    entryState_t       r_state  [DEPTH];
    logic [OP_W-1:0]   r_op     [DEPTH];
    logic [REG_W-1:0]  r_dst    [DEPTH];
    logic [DATA_W-1:0] r_valB   [DEPTH];
    logic [DATA_W-1:0] r_valC   [DEPTH];
    logic [TAG_W-1:0]  r_tagB   [DEPTH];
    logic [TAG_W-1:0]  r_tagC   [DEPTH];
    logic [DEPTH-1:0]  r_pendB;
    logic [DEPTH-1:0]  r_pendC;

    logic [NREG-1:0]   r_busy;
    logic [TAG_W-1:0]  r_renTag [NREG];

    logic              r_dispValid;
    logic [TAG_W-1:0]  r_dispTag;
    logic [OP_W-1:0]   r_dispOp;
    logic [REG_W-1:0]  r_dispDst;
    logic [DATA_W-1:0] r_dispB;
    logic [DATA_W-1:0] r_dispC;
    logic [TAG_W:0]    r_count;

    logic              w_issueFire;
    logic [TAG_W-1:0]  w_freeIdx;
    logic              w_pendB, w_pendC;
    logic [DATA_W-1:0] w_opB, w_opC;
    logic [DEPTH-1:0]  w_wakeB, w_wakeC, w_readyVec;
    logic              w_anyReady;
    logic [TAG_W-1:0]  w_selIdx;
    logic              w_accept, w_dispLoad, w_storeFree, w_cdbFree;

    function automatic logic isStore(input logic [OP_W-1:0] op);
        return op[OP_W-1:OP_W-2] == 2'b11;
    endfunction

    assign issue_ready = r_count < (TAG_W+1)'(DEPTH);
    assign w_issueFire = issue_valid && issue_ready;

    // A source still owned by a producer stays pending unless that producer broadcasts this cycle
    assign w_pendB = r_busy[issue_src_b] && !(cdb_valid && r_renTag[issue_src_b] == cdb_tag);
    assign w_pendC = r_busy[issue_src_c] && !(cdb_valid && r_renTag[issue_src_c] == cdb_tag);
    assign w_opB   = r_busy[issue_src_b] ? cdb_data : issue_val_b;
    assign w_opC   = r_busy[issue_src_c] ? cdb_data : issue_val_c;

    assign w_accept    = r_dispValid && (r_dispOp[OP_W-1] ? mem_ready : alu_ready);
    assign w_dispLoad  = (!r_dispValid || w_accept) && w_anyReady;
    assign w_storeFree = w_accept && isStore(r_dispOp);
    assign w_cdbFree   = cdb_valid && r_state[cdb_tag] == ST_RUN && !isStore(r_op[cdb_tag]);

    // Lowest-index free entry receives the next issued instruction
    always_comb begin
        w_freeIdx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (r_state[i] == ST_FREE) w_freeIdx = TAG_W'(i);
    end

    // Per-entry CDB operand match and the set of dispatch candidates
    always_comb begin
        w_wakeB    = '0;
        w_wakeC    = '0;
        w_readyVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wakeB[i]    = cdb_valid && r_pendB[i] && r_tagB[i] == cdb_tag;
            w_wakeC[i]    = cdb_valid && r_pendC[i] && r_tagC[i] == cdb_tag;
            w_readyVec[i] = r_state[i] == ST_READY;
        end
    end

`ifdef RS_AGE_ORDER_EN
    logic [DEPTH-1:0] r_older [DEPTH];
    logic [DEPTH-1:0] w_occupied;

    // Occupancy snapshot used to record who was already present at issue
    always_comb begin
        w_occupied = '0;
        for (int i = 0; i < DEPTH; i++) w_occupied[i] = r_state[i] != ST_FREE;
    end

    // r_older[i][j] set means entry j was issued before entry i
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (w_issueFire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_freeIdx == TAG_W'(i)) r_older[i] <= w_occupied;
                else                        r_older[i][w_freeIdx] <= 1'b0;
            end
        end
    end

    // Pick the READY entry that has no older READY entry
    always_comb begin
        w_anyReady = 1'b0;
        w_selIdx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_readyVec[i] && (w_readyVec & r_older[i]) == '0) begin
                w_anyReady = 1'b1;
                w_selIdx   = TAG_W'(i);
            end
        end
    end
`else
    // Pick the lowest-index READY entry
    always_comb begin
        w_anyReady = 1'b0;
        w_selIdx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_readyVec[i]) begin
                w_anyReady = 1'b1;
                w_selIdx   = TAG_W'(i);
            end
        end
    end
`endif

    // Entry lifecycle: issue, CDB capture, move to RUNNING on dispatch, free on completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_op[i]    <= '0;
                r_dst[i]   <= '0;
                r_valB[i]  <= '0;
                r_valC[i]  <= '0;
                r_tagB[i]  <= '0;
                r_tagC[i]  <= '0;
            end
            r_pendB <= '0;
            r_pendC <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issueFire && w_freeIdx == TAG_W'(i)) begin
                    r_state[i] <= (w_pendB || w_pendC) ? ST_WAIT : ST_READY;
                    r_op[i]    <= issue_op;
                    r_dst[i]   <= issue_dst;
                    r_valB[i]  <= w_opB;
                    r_valC[i]  <= w_opC;
                    r_tagB[i]  <= r_renTag[issue_src_b];
                    r_tagC[i]  <= r_renTag[issue_src_c];
                    r_pendB[i] <= w_pendB;
                    r_pendC[i] <= w_pendC;
                end else begin
                    if (w_wakeB[i]) begin
                        r_valB[i]  <= cdb_data;
                        r_pendB[i] <= 1'b0;
                    end
                    if (w_wakeC[i]) begin
                        r_valC[i]  <= cdb_data;
                        r_pendC[i] <= 1'b0;
                    end
                    if (r_state[i] == ST_WAIT && (!r_pendB[i] || w_wakeB[i]) && (!r_pendC[i] || w_wakeC[i]))
                        r_state[i] <= ST_READY;
                    if (w_dispLoad && w_selIdx == TAG_W'(i))
                        r_state[i] <= ST_RUN;
                    if ((w_storeFree && r_dispTag == TAG_W'(i)) || (w_cdbFree && cdb_tag == TAG_W'(i)))
                        r_state[i] <= ST_FREE;
                end
            end
        end
    end

    // Rename table: CDB retires a mapping, a same-cycle issue to that register overrides it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
            for (int r = 0; r < NREG; r++) r_renTag[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (cdb_valid && r_busy[r] && r_renTag[r] == cdb_tag) r_busy[r] <= 1'b0;
                if (w_issueFire && !isStore(issue_op) && issue_dst == REG_W'(r)) begin
                    r_busy[r]   <= 1'b1;
                    r_renTag[r] <= w_freeIdx;
                end
            end
        end
    end

    // Dispatch register: refills when empty or accepted, otherwise holds its payload
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dispValid <= 1'b0;
            r_dispTag   <= '0;
            r_dispOp    <= '0;
            r_dispDst   <= '0;
            r_dispB     <= '0;
            r_dispC     <= '0;
        end else if (w_dispLoad) begin
            r_dispValid <= 1'b1;
            r_dispTag   <= w_selIdx;
            r_dispOp    <= r_op[w_selIdx];
            r_dispDst   <= r_dst[w_selIdx];
            r_dispB     <= r_valB[w_selIdx];
            r_dispC     <= r_valC[w_selIdx];
        end else if (w_accept) begin
            r_dispValid <= 1'b0;
        end
    end

    // Occupancy: one possible issue in, up to two completions out per cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_count <= '0;
        else          r_count <= r_count + (TAG_W+1)'(w_issueFire)
                                          - (TAG_W+1)'(w_storeFree)
                                          - (TAG_W+1)'(w_cdbFree);
    end

    assign alu_valid = r_dispValid && !r_dispOp[OP_W-1];
    assign mem_valid = r_dispValid &&  r_dispOp[OP_W-1];
    assign disp_tag  = r_dispTag;
    assign disp_op   = r_dispOp;
    assign disp_dst  = r_dispDst;
    assign disp_b    = r_dispB;
    assign disp_c    = r_dispC;
    assign count     = r_count;

endmodule

// File: tb/tb_rs_tomasulo_param.sv
// tb_rs_tomasulo_param: directed bench for rs_tomasulo_param with an
// instruction-level reference model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_rs_tomasulo_param;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int OP_W   = 4;
    localparam int TAG_W  = 3;
    localparam int NREG   = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op = '0;
    logic [REG_W-1:0]  issue_dst = '0;
    logic [REG_W-1:0]  issue_src_b = '0;
    logic [REG_W-1:0]  issue_src_c = '0;
    logic [DATA_W-1:0] issue_val_b = '0;
    logic [DATA_W-1:0] issue_val_c = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              alu_valid;
    logic              alu_ready = 1'b0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [TAG_W-1:0]  disp_tag;
    logic [OP_W-1:0]   disp_op;
    logic [REG_W-1:0]  disp_dst;
    logic [DATA_W-1:0] disp_b;
    logic [DATA_W-1:0] disp_c;
    logic [TAG_W:0]    count;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    rs_tomasulo_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_dst(issue_dst), .issue_src_b(issue_src_b), .issue_src_c(issue_src_c),
        .issue_val_b(issue_val_b), .issue_val_c(issue_val_c),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .disp_tag(disp_tag), .disp_op(disp_op), .disp_dst(disp_dst),
        .disp_b(disp_b), .disp_c(disp_c), .count(count)
    );

    always #5 clock = ~clock;

    // Instruction-level model of the station contents
    typedef struct {
        bit                busy;
        bit                run;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        bit                bRdy;
        bit                cRdy;
        int                bTag;
        int                cTag;
        int                seq;
    } mEntry_t;

    mEntry_t           mEnt [DEPTH];
    int                mMap [NREG];
    bit                mDv;
    int                mDtag;
    logic [OP_W-1:0]   mDop;
    logic [REG_W-1:0]  mDdst;
    logic [DATA_W-1:0] mDb;
    logic [DATA_W-1:0] mDc;
    int                mSeq;

    function automatic bit isMemOp(input logic [OP_W-1:0] op);
        return op[OP_W-1];
    endfunction

    function automatic bit isStoreOp(input logic [OP_W-1:0] op);
        return op[OP_W-1:OP_W-2] == 2'b11;
    endfunction

    function automatic int modelCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mEnt[i].busy) n++;
        return n;
    endfunction

    function automatic int pickReady();
        int p = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mEnt[i].busy && !mEnt[i].run && mEnt[i].bRdy && mEnt[i].cRdy) begin
`ifdef RS_AGE_ORDER_EN
                if (p < 0 || mEnt[i].seq < mEnt[p].seq) p = i;
`else
                if (p < 0) p = i;
`endif
            end
        end
        return p;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mEnt[i].busy = 0; mEnt[i].run = 0; mEnt[i].op = '0; mEnt[i].dst = '0;
            mEnt[i].b = '0; mEnt[i].c = '0; mEnt[i].bRdy = 0; mEnt[i].cRdy = 0;
            mEnt[i].bTag = -1; mEnt[i].cTag = -1; mEnt[i].seq = 0;
        end
        for (int r = 0; r < NREG; r++) mMap[r] = -1;
        mDv = 0; mDtag = 0; mDop = '0; mDdst = '0; mDb = '0; mDc = '0; mSeq = 0;
    endtask

    task automatic resolve(input logic [REG_W-1:0] src, input logic [DATA_W-1:0] rf,
                           output logic [DATA_W-1:0] v, output bit rdy, output int tag);
        tag = mMap[src];
        rdy = 1;
        v   = rf;
        if (mMap[src] >= 0) begin
            if (cdb_valid && mMap[src] == int'(cdb_tag)) v = cdb_data;
            else begin rdy = 0; v = '0; end
        end
    endtask

    task automatic modelStep();
        int cnt, slot, pick, ct, tb, tc;
        bit acc, iss, rb, rc;
        logic [DATA_W-1:0] vb, vc;
        cnt  = modelCount();
        acc  = mDv && (isMemOp(mDop) ? mem_ready : alu_ready);
        iss  = issue_valid && (cnt < DEPTH);
        slot = -1;
        for (int i = DEPTH-1; i >= 0; i--) if (!mEnt[i].busy) slot = i;
        resolve(issue_src_b, issue_val_b, vb, rb, tb);
        resolve(issue_src_c, issue_val_c, vc, rc, tc);
        pick = pickReady();
        if (cdb_valid) begin
            ct = int'(cdb_tag);
            for (int i = 0; i < DEPTH; i++) begin
                if (mEnt[i].busy && !mEnt[i].bRdy && mEnt[i].bTag == ct) begin mEnt[i].b = cdb_data; mEnt[i].bRdy = 1; end
                if (mEnt[i].busy && !mEnt[i].cRdy && mEnt[i].cTag == ct) begin mEnt[i].c = cdb_data; mEnt[i].cRdy = 1; end
            end
            if (mEnt[ct].busy && mEnt[ct].run && !isStoreOp(mEnt[ct].op)) mEnt[ct].busy = 0;
            for (int r = 0; r < NREG; r++) if (mMap[r] == ct) mMap[r] = -1;
        end
        if (acc && isStoreOp(mDop)) mEnt[mDtag].busy = 0;
        if (!mDv || acc) begin
            if (pick >= 0) begin
                mDv = 1; mDtag = pick; mDop = mEnt[pick].op; mDdst = mEnt[pick].dst;
                mDb = mEnt[pick].b; mDc = mEnt[pick].c; mEnt[pick].run = 1;
            end else begin
                mDv = 0;
            end
        end
        if (iss && slot >= 0) begin
            mEnt[slot].busy = 1; mEnt[slot].run = 0; mEnt[slot].op = issue_op; mEnt[slot].dst = issue_dst;
            mEnt[slot].b = vb; mEnt[slot].bRdy = rb; mEnt[slot].bTag = tb;
            mEnt[slot].c = vc; mEnt[slot].cRdy = rc; mEnt[slot].cTag = tc;
            mEnt[slot].seq = mSeq;
            mSeq++;
            if (!isStoreOp(issue_op)) mMap[issue_dst] = slot;
        end
    endtask

    // Advance the model on the same edges the DUT sees
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model away from the active edge
    always @(negedge clock) begin
        if (checkEn) begin
            int cnt;
            cnt = modelCount();
            checkOutput("count", 32'(count), 32'(cnt));
            checkOutput("issue_ready", 32'(issue_ready), 32'(cnt < DEPTH));
            checkOutput("alu_valid", 32'(alu_valid), 32'(mDv && !isMemOp(mDop)));
            checkOutput("mem_valid", 32'(mem_valid), 32'(mDv && isMemOp(mDop)));
            if (mDv) begin
                checkOutput("disp_tag", 32'(disp_tag), 32'(mDtag));
                checkOutput("disp_op", 32'(disp_op), 32'(mDop));
                checkOutput("disp_dst", 32'(disp_dst), 32'(mDdst));
                checkOutput("disp_b", 32'(disp_b), 32'(mDb));
                checkOutput("disp_c", 32'(disp_c), 32'(mDc));
            end
        end
    end

    task automatic applyReset();
        reset_n = 1'b0;
        issue_valid = 1'b0; cdb_valid = 1'b0; alu_ready = 1'b0; mem_ready = 1'b0;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);
        checkOutput("rst_alu_valid", 32'(alu_valid), 32'd0);
        checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
        checkOutput("rst_disp_tag", 32'(disp_tag), 32'd0);
        checkOutput("rst_disp_b", 32'(disp_b), 32'd0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic applyStimulus(input bit iv, input logic [OP_W-1:0] op, input logic [REG_W-1:0] dst,
                                 input logic [REG_W-1:0] sb, input logic [REG_W-1:0] sc,
                                 input logic [DATA_W-1:0] vb, input logic [DATA_W-1:0] vc,
                                 input bit cv, input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
        issue_valid = iv; issue_op = op; issue_dst = dst; issue_src_b = sb; issue_src_c = sc;
        issue_val_b = vb; issue_val_c = vc;
        cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
        @(posedge clock);
        @(negedge clock);
        #1;
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
    endtask

    task automatic doIssue(input logic [OP_W-1:0] op, input logic [REG_W-1:0] dst,
                           input logic [REG_W-1:0] sb, input logic [REG_W-1:0] sc,
                           input logic [DATA_W-1:0] vb, input logic [DATA_W-1:0] vc);
        applyStimulus(1'b1, op, dst, sb, sc, vb, vc, 1'b0, '0, '0);
    endtask

    task automatic doCdb(input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, 1'b1, ct, cd);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();
        checkEn = 1;

        // Dependent ADD woken by the CDB
        alu_ready = 1'b1;
        doIssue(4'h0, 4'd1, 4'd2, 4'd3, 16'd3, 16'd4);
        checkOutput("t1_count", 32'(count), 32'd1);
        checkOutput("t1_no_same_cycle", 32'(alu_valid), 32'd0);
        doIssue(4'h0, 4'd2, 4'd1, 4'd5, 16'd0, 16'd9);
        checkOutput("t1_first_tag", 32'(disp_tag), 32'd0);
        checkOutput("t1_first_b", 32'(disp_b), 32'd3);
        checkOutput("t1_first_c", 32'(disp_c), 32'd4);
        idle();
        doCdb(3'd0, 16'd7);
        checkOutput("t1_after_cdb_count", 32'(count), 32'd1);
        checkOutput("t1_after_cdb_valid", 32'(alu_valid), 32'd0);
        idle();
        checkOutput("t1_dep_valid", 32'(alu_valid), 32'd1);
        checkOutput("t1_dep_tag", 32'(disp_tag), 32'd1);
        checkOutput("t1_dep_b", 32'(disp_b), 32'd7);
        checkOutput("t1_dep_c", 32'(disp_c), 32'd9);

        // Same-cycle CDB bypass at issue
        applyReset();
        alu_ready = 1'b1;
        doIssue(4'h1, 4'd3, 4'd10, 4'd11, 16'd1, 16'd2);
        doIssue(4'h1, 4'd4, 4'd10, 4'd11, 16'd1, 16'd2);
        doIssue(4'h1, 4'd6, 4'd10, 4'd11, 16'd1, 16'd2);
        idle();
        idle();
        applyStimulus(1'b1, 4'h2, 4'd8, 4'd6, 4'd7, 16'h0000, 16'd5, 1'b1, 3'd2, 16'h00AA);
        checkOutput("t2_count", 32'(count), 32'd3);
        checkOutput("t2_not_yet", 32'(alu_valid), 32'd0);
        idle();
        checkOutput("t2_valid", 32'(alu_valid), 32'd1);
        checkOutput("t2_tag", 32'(disp_tag), 32'd3);
        checkOutput("t2_b", 32'(disp_b), 32'h00AA);
        checkOutput("t2_c", 32'(disp_c), 32'd5);

        // Fill the station, free it with an accepted store
        applyReset();
        doIssue(4'hC, 4'd0, 4'd1, 4'd2, 16'h0011, 16'h0022);
        for (int i = 1; i < DEPTH; i++)
            doIssue(4'h1, REG_W'(i), 4'd10, 4'd11, 16'h0100 + DATA_W'(i), 16'h0200 + DATA_W'(i));
        checkOutput("t3_full_count", 32'(count), 32'd8);
        checkOutput("t3_full_ready", 32'(issue_ready), 32'd0);
        checkOutput("t3_store_valid", 32'(mem_valid), 32'd1);
        checkOutput("t3_store_tag", 32'(disp_tag), 32'd0);
        mem_ready = 1'b1;
        doIssue(4'h1, 4'd9, 4'd10, 4'd11, 16'd1, 16'd2);
        mem_ready = 1'b0;
        checkOutput("t3_freed_count", 32'(count), 32'd7);
        checkOutput("t3_freed_ready", 32'(issue_ready), 32'd1);
        checkOutput("t3_mem_dropped", 32'(mem_valid), 32'd0);
        checkOutput("t3_next_tag", 32'(disp_tag), 32'd1);

        // ALU back-pressure holds the payload
        for (int k = 0; k < 3; k++) begin
            idle();
            checkOutput("t4_hold_valid", 32'(alu_valid), 32'd1);
            checkOutput("t4_hold_tag", 32'(disp_tag), 32'd1);
            checkOutput("t4_hold_b", 32'(disp_b), 32'h0101);
            checkOutput("t4_hold_c", 32'(disp_c), 32'h0201);
        end

        // Reset while a dispatch is pending
        applyReset();

        // Age order versus index order
        alu_ready = 1'b1;
        doIssue(4'h1, 4'd1, 4'd10, 4'd11, 16'd1, 16'd1);
        doIssue(4'h1, 4'd2, 4'd10, 4'd11, 16'd2, 16'd2);
        idle();
        idle();
        alu_ready = 1'b0;
        doIssue(4'h1, 4'd3, 4'd10, 4'd11, 16'd3, 16'd3);
        doIssue(4'h1, 4'd4, 4'd3, 4'd11, 16'd0, 16'd4);
        doIssue(4'h1, 4'd5, 4'd3, 4'd11, 16'd0, 16'd5);
        doIssue(4'h1, 4'd6, 4'd10, 4'd11, 16'h0066, 16'd6);
        doCdb(3'd1, 16'h0055);
        doIssue(4'h1, 4'd7, 4'd10, 4'd11, 16'h0077, 16'd7);
        checkOutput("t5_count", 32'(count), 32'd6);
        alu_ready = 1'b1;
        idle();
`ifdef RS_AGE_ORDER_EN
        checkOutput("t5_oldest_tag", 32'(disp_tag), 32'd5);
        checkOutput("t5_oldest_b", 32'(disp_b), 32'h0066);
`else
        checkOutput("t5_lowest_tag", 32'(disp_tag), 32'd1);
        checkOutput("t5_lowest_b", 32'(disp_b), 32'h0077);
`endif
        idle();
        idle();

        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_tomasulo_param.md
# rs_tomasulo_param

Parametrised Tomasulo reservation station: DEPTH entries, DATA_W operands, built-in register-status (rename) table, registered dispatch toward ALU and memory units. Sits between the instruction queue and the execution units and listens to the common data bus (CDB). Accepts one instruction per cycle, resolves operand dependencies by producer tag, captures results from the CDB, and dispatches one ready instruction per cycle under valid/ready handshakes.

## Interface
- DEPTH, 8, station entries (power of two, ≥2); localparam TAG_W = $clog2(DEPTH)
- DATA_W, 16, operand/result width
- REG_W, 4, architectural register index width (2**REG_W registers)
- OP_W, 4, opcode width; op[OP_W-1:OP_W-2]: 2'b11 store, 2'b10 load, else ALU
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  free entry available (combinational, = count < DEPTH)
- issue_op  in  OP_W  opcode
- issue_dst  in  REG_W  destination register
- issue_src_b, issue_src_c  in  REG_W  source registers
- issue_val_b, issue_val_c  in  DATA_W  register-file values for sources
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing entry
- cdb_data  in  DATA_W  result
- alu_valid  out  1  dispatch payload targets ALU
- alu_ready  in  1  ALU accepts
- mem_valid  out  1  dispatch payload targets memory (load/store)
- mem_ready  in  1  memory accepts
- disp_tag  out  TAG_W  entry index
- disp_op  out  OP_W; disp_dst  out  REG_W; disp_b, disp_c  out  DATA_W  operands
- count  out  TAG_W+1  occupied entries

## Operation
- Entry states: FREE → (issue) WAIT or READY; WAIT → (both operands captured) READY; READY → (loaded into dispatch register) RUNNING; RUNNING → FREE on CDB with matching tag (load/ALU) or on handshake acceptance (store).
- Issue: handshake issue_valid && issue_ready; writes the FREE entry selected by priority (lowest index). Each source: if rename table[src] busy, store tag and mark pending, else take issue_val. If table[src] busy and its tag equals cdb_tag with cdb_valid, capture cdb_data (same-cycle bypass).
- Rename table: load/ALU issue sets table[issue_dst] = {busy, new tag}; stores write nothing. CDB clears busy where table tag == cdb_tag. Issue write to the same register in the same cycle wins over CDB clear.
- Wakeup: every pending operand whose tag equals cdb_tag captures cdb_data. CDB frees its tag's entry only when RUNNING; otherwise freeing ignored, wakeup still applied.
- Dispatch register: loads the selected READY entry when empty or when current payload is accepted (valid && matching ready). alu_valid/mem_valid mutually exclusive; payload held stable while not accepted.
- count: +1 per issue, −1 per free; simultaneous issue and free leave it unchanged.

## Timing
- Reset (async, any time, including mid-dispatch): all entries FREE, rename table not busy, alu_valid=mem_valid=0, disp_* = 0, count=0; issue_ready=1 in the first cycle after reset release.
- Issue with ready operands accepted at edge E → alu_valid/mem_valid high after edge E+1 (no same-cycle issue-to-dispatch).
- CDB at edge E wakes dependant → dispatchable at edge E+1.
- Back-to-back dispatch: one payload per cycle when ready held high.
- Full: issue_ready=0 while count==DEPTH; a free at edge E raises issue_ready after E.
- Tag reuse: freed entry may reissue at the same edge as its free only from the following cycle (FREE visible after E).

## Configuration
- RS_AGE_ORDER_EN defined: dispatch selects the oldest READY entry (per-entry issue age, wrap-safe ordering over DEPTH entries).
- Undefined: dispatch selects the lowest-index READY entry; no age storage.

## Test plan
- Reset mid-dispatch: alu_valid=1, alu_ready=0, drop reset_n → alu_valid=0, count=0, issue_ready=1 immediately.
- ADD r1 (vals 3,4), then ADD r2=r1+r5 → second entry WAIT with tag 0; CDB tag 0 data 7 → second dispatches with disp_b=7 one edge later.
- Issue consumer in the same cycle as CDB tag 2 data 0x00AA for its producer → operand captured as 0x00AA, dispatch after next edge.
- Fill 8 entries → issue_ready=0, count=8; store accepted by memory → entry freed, issue_ready=1 next cycle.
- alu_ready held 0 for 3 cycles → disp_* unchanged, alu_valid stays 1; no loss.
- RS_AGE_ORDER_EN: entries 5 (older) and 1 both READY → disp_tag=5; without macro → disp_tag=1.
